// File: rtl/kf_pkg.sv
// Shared types and helpers for the constant-gain Kalman filter engine:
// sequencer state encoding, coefficient-memory region offsets and the
// round-and-saturate step applied when a matrix row finishes.
package kf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INNOV  = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } kf_state_e;

  // Working width of round_sat; the accumulator is sign-extended into it.
  localparam int RS_W = 64;

  typedef struct packed {
    logic              sat;
    logic [RS_W-1:0]   val;
  } rs_t;

  // Word offsets of each region in the flat coefficient/state memory.
  function automatic int base_a(input int nx, input int nu, input int ny);
    return 0 * (nx + nu + ny);
  endfunction

  function automatic int base_b(input int nx, input int nu, input int ny);
    return base_a(nx, nu, ny) + nx * nx;
  endfunction

  function automatic int base_c(input int nx, input int nu, input int ny);
    return base_b(nx, nu, ny) + nx * nu;
  endfunction

  function automatic int base_k(input int nx, input int nu, input int ny);
    return base_c(nx, nu, ny) + ny * nx;
  endfunction

  function automatic int base_x(input int nx, input int nu, input int ny);
    return base_k(nx, nu, ny) + nx * ny;
  endfunction

  function automatic int n_words(input int nx, input int nu, input int ny);
    return base_x(nx, nu, ny) + nx;
  endfunction

  // Round half-up at bit FRAC, drop the fraction, clamp to a W-bit signed
  // range. The clamped value is returned sign-extended to RS_W bits.
  function automatic rs_t round_sat(input logic signed [RS_W-1:0] acc,
                                    input int frac, input int w);
    logic signed [RS_W-1:0] one;
    logic signed [RS_W-1:0] half;
    logic signed [RS_W-1:0] rnd;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    rs_t                    r;
    one  = 1;
    half = one <<< (frac - 1);
    rnd  = (acc + half) >>> frac;
    hi   = (one <<< (w - 1)) - one;
    lo   = -(one <<< (w - 1));
    if (rnd > hi) begin
      r.val = hi;
      r.sat = 1'b1;
    end else if (rnd < lo) begin
      r.val = lo;
      r.sat = 1'b1;
    end else begin
      r.val = rnd;
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/kf_mac.sv
// Single signed multiply-accumulate lane shared by every matrix product.
// The row result (accumulator plus this cycle's product, rounded and
// saturated) is presented combinationally so the sequencer can commit it
// on the same edge as the row's last MAC.
module kf_mac
  import kf_pkg::*;
#(
  parameter int W     = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 2 * W + 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             i_en,
  input  logic             i_first,
  input  logic             i_sub,
  input  logic [ACC_W-1:0] i_seed,
  input  logic [W-1:0]     i_a,
  input  logic [W-1:0]     i_b,
  output logic [W-1:0]     o_res,
  output logic             o_sat
);

  logic signed [2*W-1:0]   w_a_ext;
  logic signed [2*W-1:0]   w_b_ext;
  logic signed [2*W-1:0]   w_prod;
  logic signed [ACC_W-1:0] w_base;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] r_acc;
  rs_t                     w_rs;

  // Full-precision product, seeded/accumulated sum and its rounded result.
  // NOTE: every combinational output gets a value on every path, otherwise
  // synthesis infers a latch to hold the old value.
  always_comb begin
    w_a_ext = (2 * W)'($signed(i_a));
    w_b_ext = (2 * W)'($signed(i_b));
    w_prod  = w_a_ext * w_b_ext;
    w_base  = i_first ? $signed(i_seed) : r_acc;
    w_sum   = i_sub ? (w_base - ACC_W'(w_prod)) : (w_base + ACC_W'(w_prod));
    w_rs    = round_sat(RS_W'(w_sum), FRAC, W);
    o_res   = W'(w_rs.val);
    o_sat   = w_rs.sat;
  end

  // Accumulator advances once per enabled MAC cycle.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if (clk_en && i_en) begin
      r_acc <= w_sum;
    end
  end

endmodule

// File: rtl/kf_stream_engine.sv
// Constant-gain Kalman filter engine: x <- A*x + B*u + K*(y - C*x).
// One sample at a time: INNOV computes the innovation e with one MAC per
// cycle, UPDATE computes the next state into a shadow, the last MAC commits
// it to x, and DONE holds the estimate until the consumer takes it.
module kf_stream_engine
  import kf_pkg::*;
#(
  parameter  int W      = 16,
  parameter  int FRAC   = 8,
  parameter  int NX     = 4,
  parameter  int NU     = 2,
  parameter  int NY     = 2,
  parameter  int ACC_W  = 2 * W + 4,
  localparam int NWORDS = n_words(NX, NU, NY),
  localparam int AW     = $clog2(NWORDS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clk_en,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NU*W-1:0] u_i,
  input  logic [NY*W-1:0] y_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NX*W-1:0] state_o,
  output logic            sat_o,
  input  logic            cfg_we,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [W-1:0]    cfg_data
);

  localparam int BASE_A = base_a(NX, NU, NY);
  localparam int BASE_B = base_b(NX, NU, NY);
  localparam int BASE_C = base_c(NX, NU, NY);
  localparam int BASE_K = base_k(NX, NU, NY);
  localparam int BASE_X = base_x(NX, NU, NY);
  localparam int NCOL   = NX + NU + NY;
  localparam int CNT_W  = $clog2(NCOL + 1);

  kf_state_e        r_state;
  kf_state_e        w_next;
  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_col;
  logic [W-1:0]     r_mem [NWORDS];
  logic [W-1:0]     r_u   [NU];
  logic [W-1:0]     r_y   [NY];
  logic [W-1:0]     r_e   [NY];
  logic [W-1:0]     r_xn  [NX];
  logic             r_sat;

  logic             w_accept;
  logic             w_mac_en;
  logic             w_col_last;
  logic             w_row_last;
  logic             w_phase_end;
  logic             w_update_end;
  logic             w_first;
  logic             w_sub;
  logic [AW-1:0]    w_a_idx;
  logic [W-1:0]     w_a;
  logic [W-1:0]     w_b;
  logic [ACC_W-1:0] w_seed;
  logic [W-1:0]     w_res;
  logic             w_sat;

  assign w_accept     = in_valid & in_ready;
  assign w_phase_end  = w_col_last & w_row_last;
  assign w_update_end = (r_state == UPDATE) & w_phase_end;
  assign sat_o        = r_sat;

  // Phase register; clk_en low freezes the sequencer in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else if (clk_en) begin
      r_state <= w_next;
    end
  end

  // Phase transitions: accept, end of INNOV, end of UPDATE, output taken.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)    w_next = INNOV;
      INNOV:   if (w_phase_end) w_next = UPDATE;
      UPDATE:  if (w_phase_end) w_next = DONE;
      DONE:    if (out_ready)   w_next = IDLE;
      default:                  w_next = IDLE;
    endcase
  end

  // Per-phase outputs: handshakes, MAC enable and row/column wrap points.
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    w_mac_en   = 1'b0;
    w_col_last = 1'b0;
    w_row_last = 1'b0;
    unique case (r_state)
      IDLE:    in_ready = 1'b1;
      INNOV: begin
        w_mac_en   = 1'b1;
        w_col_last = (r_col == CNT_W'(NX - 1));
        w_row_last = (r_row == CNT_W'(NY - 1));
      end
      UPDATE: begin
        w_mac_en   = 1'b1;
        w_col_last = (r_col == CNT_W'(NCOL - 1));
        w_row_last = (r_row == CNT_W'(NX - 1));
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Row/column walk over the current product; both wrap to 0 at phase end.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (clk_en && w_mac_en) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Operand selection. INNOV: seed y_j<<FRAC and subtract C[j][k]*x_k.
  // UPDATE: columns run over A|B|K against x|u|e, seeded with zero.
  always_comb begin
    w_a_idx = '0;
    w_b     = '0;
    w_seed  = '0;
    w_sub   = 1'b0;
    w_first = (r_col == '0);
    if (r_state == INNOV) begin
      w_sub   = 1'b1;
      w_a_idx = AW'(BASE_C + int'(r_row) * NX + int'(r_col));
      w_b     = r_mem[AW'(BASE_X + int'(r_col))];
      for (int n = 0; n < NY; n++) begin
        if (r_row == CNT_W'(n)) w_seed = ACC_W'($signed(r_y[n])) <<< FRAC;
      end
    end else if (r_state == UPDATE) begin
      if (int'(r_col) < NX) begin
        w_a_idx = AW'(BASE_A + int'(r_row) * NX + int'(r_col));
        w_b     = r_mem[AW'(BASE_X + int'(r_col))];
      end else if (int'(r_col) < NX + NU) begin
        w_a_idx = AW'(BASE_B + int'(r_row) * NU + int'(r_col) - NX);
        for (int n = 0; n < NU; n++) begin
          if (r_col == CNT_W'(NX + n)) w_b = r_u[n];
        end
      end else begin
        w_a_idx = AW'(BASE_K + int'(r_row) * NY + int'(r_col) - NX - NU);
        for (int n = 0; n < NY; n++) begin
          if (r_col == CNT_W'(NX + NU + n)) w_b = r_e[n];
        end
      end
    end
    w_a = r_mem[w_a_idx];
  end

  kf_mac #(
    .W     (W),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .clk_en  (clk_en),
    .i_en    (w_mac_en),
    .i_first (w_first),
    .i_sub   (w_sub),
    .i_seed  (w_seed),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_res   (w_res),
    .o_sat   (w_sat)
  );

  // Sample capture, row results (e in INNOV, shadow xn in UPDATE), sat flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NU; n++) r_u[n] <= '0;
      for (int n = 0; n < NY; n++) r_y[n] <= '0;
      for (int n = 0; n < NY; n++) r_e[n] <= '0;
      for (int n = 0; n < NX; n++) r_xn[n] <= '0;
      r_sat <= 1'b0;
    end else if (clk_en) begin
      if (w_accept) begin
        for (int n = 0; n < NU; n++) r_u[n] <= u_i[n*W +: W];
        for (int n = 0; n < NY; n++) r_y[n] <= y_i[n*W +: W];
        r_sat <= 1'b0;
      end
      if (w_mac_en && w_col_last) begin
        if (w_sat) r_sat <= 1'b1;
        if (r_state == INNOV) begin
          for (int n = 0; n < NY; n++) begin
            if (r_row == CNT_W'(n)) r_e[n] <= w_res;
          end
        end else begin
          for (int n = 0; n < NX; n++) begin
            if (r_row == CNT_W'(n)) r_xn[n] <= w_res;
          end
        end
      end
    end
  end

  // Coefficient and state memory: host writes while idle, commit of xn at
  // the end of UPDATE with the final row taken straight from the MAC.
  // NOTE: this array is reset explicitly so an unconfigured filter yields a
  // defined all-zero estimate; that forces flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NWORDS; n++) r_mem[n] <= '0;
    end else if (clk_en) begin
      if (r_state == IDLE && cfg_we && int'(cfg_addr) < NWORDS) begin
        r_mem[cfg_addr] <= cfg_data;
      end
      if (w_update_end) begin
        for (int n = 0; n < NX - 1; n++) r_mem[BASE_X + n] <= r_xn[n];
        r_mem[BASE_X + NX - 1] <= w_res;
      end
    end
  end

  // The estimate output is a direct view of x.
  always_comb begin
    state_o = '0;
    for (int n = 0; n < NX; n++) state_o[n*W +: W] = r_mem[BASE_X + n];
  end

endmodule

// File: tb/tb_kf_stream_engine.sv
// Directed bench for kf_stream_engine with the default 4/2/2, Q8.8 sizing.
// Address map: A 0..15, B 16..23, C 24..31, K 32..39, X0 40..43.
module tb_kf_stream_engine;

  localparam int W  = 16;
  localparam int NX = 4;
  localparam int NU = 2;
  localparam int NY = 2;
  localparam int AW = 6;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            clk_en = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [NU*W-1:0] u_i = '0;
  logic [NY*W-1:0] y_i = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [NX*W-1:0] state_o;
  logic            sat_o;
  logic            cfg_we = 1'b0;
  logic [AW-1:0]   cfg_addr = '0;
  logic [W-1:0]    cfg_data = '0;

  int n_checks = 0;
  int n_errors = 0;
  bit gate = 1'b0;

  kf_stream_engine #(
    .W    (W),
    .FRAC (8),
    .NX   (NX),
    .NU   (NU),
    .NY   (NY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .u_i       (u_i),
    .y_i       (y_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_o   (state_o),
    .sat_o     (sat_o),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint xs(input int i);
    return longint'($signed(state_o[i*W +: W]));
  endfunction

  // One clock; in gated mode clk_en alternates every edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (gate) clk_en = ~clk_en;
    else      clk_en = 1'b1;
  endtask

  // Reset is applied with clk_en low to show that reset dominates.
  task automatic do_reset();
    reset  = 1'b1;
    clk_en = 1'b0;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    clk_en = 1'b1;
  endtask

  task automatic wr(input int addr, input int data);
    cfg_we   = 1'b1;
    cfg_addr = AW'(addr);
    cfg_data = W'(data);
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic send(input int u0, input int u1, input int y0, input int y1);
    int n;
    u_i      = {W'(u1), W'(u0)};
    y_i      = {W'(y1), W'(y0)};
    in_valid = 1'b1;
    tick();
    n = 1;
    while (in_ready && n < 100) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("accepted", in_ready, 0);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 400) begin
      tick();
      lat++;
    end
    check("out_valid_rise", out_valid, 1);
  endtask

  task automatic take();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 10) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    check("in_ready_after_take", in_ready, 1);
  endtask

  task automatic chk_x(input string tag, input int e0, input int e1,
                       input int e2, input int e3);
    check({tag, "_x0"}, xs(0), e0);
    check({tag, "_x1"}, xs(1), e1);
    check({tag, "_x2"}, xs(2), e2);
    check({tag, "_x3"}, xs(3), e3);
  endtask

  task automatic cfg_identity();
    for (int i = 0; i < NX; i++) wr(i * NX + i, 256);
  endtask

  initial begin
    int lat;
    do_reset();

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_state", longint'(state_o), 0);
    check("rst_sat", sat_o, 0);

    // Hold-through: A = I, x carried unchanged, 40-cycle latency
    cfg_identity();
    wr(40, 256); wr(41, 512); wr(42, -256); wr(43, 0);
    send(0, 0, 0, 0);
    wait_out(lat);
    check("hold_latency", lat, 40);
    chk_x("hold", 256, 512, -256, 0);
    check("hold_sat", sat_o, 0);
    repeat (5) tick();
    check("hold_out_valid_held", out_valid, 1);
    check("hold_in_ready_low", in_ready, 0);
    chk_x("hold_stable", 256, 512, -256, 0);
    take();

    // Integrator: x0 += 1.0 * 0.5 each sample
    do_reset();
    cfg_identity();
    wr(16, 256);
    send(128, 0, 0, 0); wait_out(lat); check("integ_1", xs(0), 128); take();
    send(128, 0, 0, 0); wait_out(lat); check("integ_2", xs(0), 256); take();
    send(128, 0, 0, 0); wait_out(lat); check("integ_3", xs(0), 384); take();

    // Correction through the innovation path
    do_reset();
    cfg_identity();
    wr(24, 256); wr(29, 256);
    wr(32, 128); wr(35, 128);
    send(0, 0, 512, -512);
    wait_out(lat);
    chk_x("corr", 256, -256, 0, 0);
    check("corr_sat", sat_o, 0);
    take();

    // Saturation and round half-up, then sat clears on the next sample
    do_reset();
    wr(0, 512); wr(5, 128);
    wr(40, 30000); wr(41, 3);
    send(0, 0, 0, 0);
    wait_out(lat);
    chk_x("sat", 32767, 2, 0, 0);
    check("sat_flag", sat_o, 1);
    take();
    wr(0, 256);
    send(0, 0, 0, 0);
    wait_out(lat);
    chk_x("sat_edge", 32767, 1, 0, 0);
    check("sat_cleared", sat_o, 0);
    take();

    // Flow control: ungated reference run
    do_reset();
    cfg_identity();
    wr(16, 256); wr(19, -256);
    wr(40, 10); wr(41, 20); wr(42, 30); wr(43, 40);
    send(128, 64, 0, 0);
    wait_out(lat);
    check("flow_ref_latency", lat, 40);
    chk_x("flow_ref", 138, -44, 30, 40);
    take();

    // Same sample with clk_en at 50%, a stray A write during INNOV,
    // and the consumer stalling for 10 cycles
    wr(40, 10); wr(41, 20); wr(42, 30); wr(43, 40);
    gate = 1'b1;
    send(128, 64, 0, 0);
    cfg_we   = 1'b1;
    cfg_addr = AW'(0);
    cfg_data = '0;
    tick();
    tick();
    cfg_we = 1'b0;
    wait_out(lat);
    check("flow_gated_latency", lat + 2, 80);
    repeat (10) tick();
    check("flow_stall_out_valid", out_valid, 1);
    check("flow_stall_in_ready", in_ready, 0);
    chk_x("flow_gated", 138, -44, 30, 40);
    take();
    gate   = 1'b0;
    clk_en = 1'b1;

    // Reset in the middle of UPDATE with the consumer not ready
    wr(0, 512); wr(40, 30000);
    u_i      = '0;
    y_i      = '0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    check("mid_in_ready_low", in_ready, 0);
    check("mid_sat_set", sat_o, 1);
    do_reset();
    check("mrst_out_valid", out_valid, 0);
    check("mrst_in_ready", in_ready, 1);
    check("mrst_state", longint'(state_o), 0);
    check("mrst_sat", sat_o, 0);
    send(100, -100, 300, -300);
    wait_out(lat);
    chk_x("mrst_coef_cleared", 0, 0, 0, 0);
    take();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
